// File: rtl/i2c_poll_scheduler_pkg.sv
// Shared constants and state encodings for the I2C register poll scheduler.
// Address widths follow the 7-bit I2C device / 8-bit register convention.
package i2c_poll_scheduler_pkg;

    localparam int DEV_ADDR_W = 7;
    localparam int REG_ADDR_W = 8;
    localparam int DATA_W     = 8;
    localparam int IDX_W      = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_ISSUE    = 2'd1;
    localparam state_t ST_WAIT_RSP = 2'd2;
    localparam state_t ST_NEXT     = 2'd3;

    // Register address for slot idx of a pass; wraps modulo 256.
    function automatic logic [REG_ADDR_W-1:0] reg_addr(
        input logic [REG_ADDR_W-1:0] base,
        input logic [IDX_W-1:0]      idx
    );
        return base + {{(REG_ADDR_W-IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/i2c_poll_scheduler_if.sv
// Request/response channel between the poll scheduler and the I2C master engine.
// master = scheduler side (issues reads), slave = I2C engine side.
interface i2c_poll_scheduler_if;
    import i2c_poll_scheduler_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [DEV_ADDR_W-1:0] req_dev_addr;
    logic [REG_ADDR_W-1:0] req_reg_addr;
    logic                  rsp_valid;
    logic                  rsp_nack;
    logic [DATA_W-1:0]     rsp_data;

    modport master (
        output req_valid, req_dev_addr, req_reg_addr,
        input  req_ready, rsp_valid, rsp_nack, rsp_data
    );

    modport slave (
        input  req_valid, req_dev_addr, req_reg_addr,
        output req_ready, rsp_valid, rsp_nack, rsp_data
    );

endinterface

// File: rtl/i2c_poll_scheduler_rsp_timeout_counter.sv
// Response watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches RSP_TIMEOUT-1; it then holds until cleared.
module rsp_timeout_counter #(
    parameter int RSP_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RSP_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == LAST);

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every always_ff block sees pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_poll_scheduler.sv
// Periodic I2C register poller: on each enabled tick, reads NUM_REGS consecutive
// registers of one device, retrying NACKs/timeouts and reporting each result.
module i2c_poll_scheduler
    import i2c_poll_scheduler_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int MAX_RETRY   = 3,
    parameter int RSP_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  tick,
    input  logic [DEV_ADDR_W-1:0] dev_addr,
    input  logic [REG_ADDR_W-1:0] reg_base,
    i2c_poll_scheduler_if.master  bus,
    output logic                  out_valid,
    output logic [IDX_W-1:0]      out_index,
    output logic [DATA_W-1:0]     out_data,
    output logic                  busy,
    output logic                  missed_tick,
    output logic [7:0]            err_count
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REGS - 1);

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [RETRY_W-1:0]    retry;
    logic [DEV_ADDR_W-1:0] dev_q;
    logic [REG_ADDR_W-1:0] base_q;
    logic                  handshake;
    logic                  expired;

    assign handshake        = (state == ST_ISSUE) && bus.req_ready;
    assign busy             = (state != ST_IDLE);
    assign bus.req_valid    = (state == ST_ISSUE);
    assign bus.req_dev_addr = dev_q;
    assign bus.req_reg_addr = reg_addr(base_q, idx);

    rsp_timeout_counter #(
        .RSP_TIMEOUT (RSP_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (handshake),
        .enable  (state == ST_WAIT_RSP),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            retry       <= '0;
            dev_q       <= '0;
            base_q      <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_data    <= '0;
            missed_tick <= 1'b0;
            err_count   <= '0;
        end else begin
            out_valid   <= 1'b0;
            missed_tick <= tick && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (tick && enable) begin
                        dev_q  <= dev_addr;
                        base_q <= reg_base;
                        idx    <= '0;
                        retry  <= '0;
                        state  <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (bus.req_ready) begin
                        state <= ST_WAIT_RSP;
                    end
                end

                ST_WAIT_RSP: begin
                    // A response wins over a coincident timeout.
                    if (bus.rsp_valid && !bus.rsp_nack) begin
                        out_valid <= 1'b1;
                        out_index <= idx;
                        out_data  <= bus.rsp_data;
                        state     <= ST_NEXT;
                    end else if (bus.rsp_valid || expired) begin
                        if (retry < RETRY_LIMIT) begin
                            retry <= retry + RETRY_W'(1);
                            state <= ST_ISSUE;
                        end else begin
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                            state <= ST_NEXT;
                        end
                    end
                end

                default: begin
                    if (idx == LAST_IDX || !enable) begin
                        state <= ST_IDLE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        retry <= '0;
                        state <= ST_ISSUE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_poll_scheduler.md
I2C_POLL_SCHEDULER -- requirements
Module: i2c_poll_scheduler

Interface
REQ-001 Parameter NUM_REGS, default 4, sets the number of consecutive registers read per poll pass (1..16).
REQ-002 Parameter MAX_RETRY, default 3, sets the number of re-issues after a NACK or timeout before a register is abandoned.
REQ-003 Parameter RSP_TIMEOUT, default 1024, sets the number of cycles waited for a response before a timeout is declared.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  permits new poll passes.
REQ-007 tick  input  1  one-cycle poll trigger, driven by the periodic timer's done output.
REQ-008 dev_addr  input  7  I2C slave address; latched at pass start.
REQ-009 reg_base  input  8  first register address; latched at pass start.
REQ-010 req_valid / req_ready  output / input  1 / 1  read-request handshake to the I2C master.
REQ-011 req_dev_addr, req_reg_addr  output  7, 8  request payload.
REQ-012 rsp_valid, rsp_nack, rsp_data  input  1, 1, 8  response from the I2C master; qualified by rsp_valid.
REQ-013 out_valid, out_index, out_data  output  1, 4, 8  one-cycle result strobe, register index within the pass, and read data.
REQ-014 busy, missed_tick, err_count  output  1, 1, 8  pass active, dropped-tick pulse, and saturating abandon count.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_RSP and NEXT.
REQ-016 IDLE: on tick=1 and enable=1, SHALL latch dev_addr/reg_base, clear idx and retry count, and go to ISSUE the next cycle.
REQ-017 ISSUE: req_valid=1, req_reg_addr=reg_base+idx (mod 256); payload SHALL be stable and valid held until req_ready=1.
REQ-018 On the req_valid&&req_ready cycle, the FSM SHALL go to WAIT_RSP and clear the timeout counter.
REQ-019 WAIT_RSP with rsp_valid=1 and rsp_nack=0: SHALL pulse out_valid for 1 cycle the next cycle with out_index=idx and out_data=rsp_data, then go to NEXT.
REQ-020 WAIT_RSP with rsp_nack=1, or with the timeout counter reaching RSP_TIMEOUT-1 and no rsp_valid: SHALL retry (ISSUE, retry+1) while retry<MAX_RETRY; otherwise SHALL increment err_count (saturating at 255), issue no out_valid, and go to NEXT.
REQ-021 rsp_valid and the timeout in the same cycle: the response SHALL take priority.
REQ-022 rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-023 NEXT: SHALL go to IDLE if idx==NUM_REGS-1 or enable=0; otherwise SHALL increment idx, clear retry and go to ISSUE.
REQ-024 enable=0 SHALL NOT abort ISSUE or WAIT_RSP; an accepted request always completes.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A tick while busy=1 SHALL be dropped and SHALL pulse missed_tick for 1 cycle; a tick in IDLE with enable=0 SHALL be ignored silently.
REQ-027 Minimum latency: tick to req_valid SHALL be 1 cycle; rsp_valid to out_valid SHALL be 1 cycle.

Reset
REQ-028 rst=1 SHALL force IDLE and clear idx, retry, timeout counter, err_count, req_valid, out_valid, missed_tick, busy, and all output payload registers to 0 on the next edge.
REQ-029 rst mid-pass SHALL abandon the pass with no out_valid and no err_count change; rst has priority over all inputs.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the I2C address width constants (7-bit device, 8-bit register).
REQ-031 The response timeout SHALL be a sub-module, rsp_timeout_counter, with clear and enable inputs and an expired output.

Verification
REQ-032 Bench SHALL cover: NUM_REGS=4, reg_base=0x10, tick, immediate ready, responses 0xA0..0xA3 -> requests to 0x10..0x13, out_index 0..3, busy drops after the last result.
REQ-033 Bench SHALL cover: NACK on register 1 twice, then ACK 0x55 -> 3 requests to 0x11 and a single out_valid with index 1 / data 0x55, err_count=0.
REQ-034 Bench SHALL cover: no response for register 2, MAX_RETRY=3 -> 4 requests each spaced RSP_TIMEOUT cycles apart, err_count=1, pass continues to register 3.
REQ-035 Bench SHALL cover: req_ready held low 10 cycles -> req_valid and payload stable all 10 cycles.
REQ-036 Bench SHALL cover: tick during a pass -> one missed_tick pulse and no extra pass; enable dropped during register 1 -> register 1 completes, then IDLE.
REQ-037 Bench SHALL cover: rst asserted in WAIT_RSP -> all outputs 0 next cycle; a later rsp_valid is ignored.
